// File: rtl/mem_w_ctrl.sv
// -----------------------------------------------------------------------------
// mem_w_ctrl
//   Write-side controller for the shared feature RAM of the BWN/BNN
//   accelerator. Each accepted producer strobe becomes one registered RAM
//   write (address, enable, data) one clock later. The phase/stage sequence
//   mirrors the RAM read sequencer:
//     phase A : SPI loader -> RAM,  CNT_A words/stage, CNT_STAGE stages
//     phase B : Conv1      -> RAM,  CNT_B words/stage, CNT_STAGE stages
//     phase C : Conv2      -> RAM,  CNT_C words/stage, CNT_STAGE stages
//     phase D : Conv3      -> RAM,  CNT_D words/loop,  CNT_STAGE_FC loops
//
// Ports
//   iCLK         clock, rising edge
//   iRSTn        asynchronous active-low reset
//   iSTART_BWN   arms one phase-A stage (honoured only in W_IDLE_A)
//   iSTART_BNN   one-hot arm: 0010 phase B, 0100 phase C, 1000 phase D
//   iWR_VALID    producer word strobe
//   iWDATA       producer word
//   oWADDR       RAM write address (holds between writes)
//   oWDATA       RAM write data    (holds between writes)
//   oEN_WC       RAM write enable, one cycle per accepted strobe
//   oSTAGE_DONE  high for the single cycle spent in a W_STG_x state
//   oALL_DONE    high in the W_STG_D cycle that ends the last FC loop
//   oBUSY        high in every write and stage-end state
//   oERR         (MEM_W_CTRL_OVF_CHK_EN only) sticky flag: a strobe arrived
//                while no write phase was active; cleared only by reset
//
// Build option
//   MEM_W_CTRL_OVF_CHK_EN  adds the oERR port and its sticky logic. Write
//                          behaviour is identical with or without it.
// -----------------------------------------------------------------------------
module mem_w_ctrl #(
  parameter int DW           = 8,
  parameter int CNT_A        = 238,
  parameter int CNT_B        = 154,
  parameter int CNT_C        = 108,
  parameter int CNT_D        = 54,
  parameter int CNT_STAGE    = 48,
  parameter int CNT_STAGE_FC = 5
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART_BWN,
  input  logic [3:0]    iSTART_BNN,
  input  logic          iWR_VALID,
  input  logic [DW-1:0] iWDATA,
  output logic [7:0]    oWADDR,
  output logic [DW-1:0] oWDATA,
  output logic          oEN_WC,
  output logic          oSTAGE_DONE,
  output logic          oALL_DONE,
`ifdef MEM_W_CTRL_OVF_CHK_EN
  output logic          oERR,
`endif
  output logic          oBUSY
);

  typedef enum logic [3:0] {
    W_IDLE_A, W_A, W_STG_A,
    W_IDLE_B, W_B, W_STG_B,
    W_IDLE_C, W_C, W_STG_C,
    W_IDLE_D, W_D, W_STG_D
  } state_t;

  // Start codes on iSTART_BNN; anything else is ignored in the matching idle.
  localparam logic [3:0] START_B = 4'b0010;
  localparam logic [3:0] START_C = 4'b0100;
  localparam logic [3:0] START_D = 4'b1000;

  // Terminal counts. Phase C/D counters are narrower than the RAM address.
  localparam logic [7:0] LAST_A     = 8'(CNT_A - 1);
  localparam logic [7:0] LAST_B     = 8'(CNT_B - 1);
  localparam logic [6:0] LAST_C     = 7'(CNT_C - 1);
  localparam logic [5:0] LAST_D     = 6'(CNT_D - 1);
  localparam logic [5:0] LAST_STAGE = 6'(CNT_STAGE - 1);
  localparam logic [2:0] LAST_FC    = 3'(CNT_STAGE_FC - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0] r_cnt_a;
  logic [7:0] r_cnt_b;
  logic [6:0] r_cnt_c;
  logic [5:0] r_cnt_d;
  logic [5:0] r_stage;
  logic [2:0] r_fc;

  logic [7:0]    r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_en_wc;

  logic       w_in_write;   // in W_A/W_B/W_C/W_D
  logic       w_in_stg;     // in any W_STG_x
  logic       w_accept;     // strobe accepted this cycle
  logic [7:0] w_addr_cur;   // word counter of the active phase, zero-extended
  logic       w_last_a;
  logic       w_last_b;
  logic       w_last_c;
  logic       w_last_d;
  logic       w_last_stage;
  logic       w_last_fc;

  // ---------------------------------------------------------------------------
  // State decode
  // ---------------------------------------------------------------------------
  assign w_in_write = (r_state == W_A) || (r_state == W_B) ||
                      (r_state == W_C) || (r_state == W_D);
  assign w_in_stg   = (r_state == W_STG_A) || (r_state == W_STG_B) ||
                      (r_state == W_STG_C) || (r_state == W_STG_D);
  assign w_accept   = w_in_write && iWR_VALID;

  assign w_last_a     = (r_cnt_a == LAST_A);
  assign w_last_b     = (r_cnt_b == LAST_B);
  assign w_last_c     = (r_cnt_c == LAST_C);
  assign w_last_d     = (r_cnt_d == LAST_D);
  assign w_last_stage = (r_stage == LAST_STAGE);
  assign w_last_fc    = (r_fc == LAST_FC);

  // Address presented for the current accept: the counter value before it
  // increments.
  always_comb begin
    w_addr_cur = 8'd0;
    case (r_state)
      W_A:     w_addr_cur = r_cnt_a;
      W_B:     w_addr_cur = r_cnt_b;
      W_C:     w_addr_cur = {1'b0, r_cnt_c};
      W_D:     w_addr_cur = {2'b00, r_cnt_d};
      default: w_addr_cur = 8'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) r_state <= W_IDLE_A;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A strobe coinciding with a start is not accepted because
  // acceptance is gated on being in a write state already.
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE_A: if (iSTART_BWN)              w_state_nxt = W_A;
      W_A:      if (iWR_VALID && w_last_a)   w_state_nxt = W_STG_A;
      W_STG_A:  w_state_nxt = w_last_stage ? W_IDLE_B : W_IDLE_A;

      W_IDLE_B: if (iSTART_BNN == START_B)   w_state_nxt = W_B;
      W_B:      if (iWR_VALID && w_last_b)   w_state_nxt = W_STG_B;
      W_STG_B:  w_state_nxt = w_last_stage ? W_IDLE_C : W_IDLE_B;

      W_IDLE_C: if (iSTART_BNN == START_C)   w_state_nxt = W_C;
      W_C:      if (iWR_VALID && w_last_c)   w_state_nxt = W_STG_C;
      W_STG_C:  w_state_nxt = w_last_stage ? W_IDLE_D : W_IDLE_C;

      W_IDLE_D: if (iSTART_BNN == START_D)   w_state_nxt = W_D;
      W_D:      if (iWR_VALID && w_last_d)   w_state_nxt = W_STG_D;
      W_STG_D:  w_state_nxt = w_last_fc ? W_IDLE_A : W_IDLE_D;

      default:  w_state_nxt = W_IDLE_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word counters: advance on accept, wrap to 0 on the last word of a stage.
  // Only the active phase's counter moves; the others rest at 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_cnt_c <= '0;
      r_cnt_d <= '0;
    end else if (iWR_VALID) begin
      case (r_state)
        W_A:     r_cnt_a <= w_last_a ? '0 : r_cnt_a + 8'd1;
        W_B:     r_cnt_b <= w_last_b ? '0 : r_cnt_b + 8'd1;
        W_C:     r_cnt_c <= w_last_c ? '0 : r_cnt_c + 7'd1;
        W_D:     r_cnt_d <= w_last_d ? '0 : r_cnt_d + 6'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage / FC-loop counters: advance once per W_STG_x visit. Phases A-C share
  // one stage counter since they run strictly one after another and each
  // leaves it at 0 on exit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_stage <= '0;
      r_fc    <= '0;
    end else begin
      case (r_state)
        W_STG_A, W_STG_B, W_STG_C:
          r_stage <= w_last_stage ? '0 : r_stage + 6'd1;
        W_STG_D:
          r_fc    <= w_last_fc ? '0 : r_fc + 3'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port: one clock after an accepted strobe. Address and
  // data hold their last values when nothing is written.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_en_wc <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_en_wc <= w_accept;
      if (w_accept) begin
        r_waddr <= w_addr_cur;
        r_wdata <= iWDATA;
      end
    end
  end

  assign oEN_WC      = r_en_wc;
  assign oWADDR      = r_waddr;
  assign oWDATA      = r_wdata;
  assign oSTAGE_DONE = w_in_stg;
  assign oALL_DONE   = (r_state == W_STG_D) && w_last_fc;
  assign oBUSY       = w_in_write || w_in_stg;

`ifdef MEM_W_CTRL_OVF_CHK_EN
  // ---------------------------------------------------------------------------
  // Sticky error on a strobe that arrives while no write phase is active.
  // ---------------------------------------------------------------------------
  logic r_err;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn)                      r_err <= 1'b0;
    else if (iWR_VALID && !w_in_write) r_err <= 1'b1;
  end

  assign oERR = r_err;
`endif

endmodule

// File: tb/tb_mem_w_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_w_ctrl
//   Directed bench for mem_w_ctrl. Inputs change 1 time unit after the rising
//   edge; outputs are sampled at the same point, so each sample shows the
//   registers loaded by the edge just passed.
// -----------------------------------------------------------------------------
module tb_mem_w_ctrl;

  localparam int DW = 8;

  logic          iCLK;
  logic          iRSTn;
  logic          iSTART_BWN;
  logic [3:0]    iSTART_BNN;
  logic          iWR_VALID;
  logic [DW-1:0] iWDATA;
  logic [7:0]    oWADDR;
  logic [DW-1:0] oWDATA;
  logic          oEN_WC;
  logic          oSTAGE_DONE;
  logic          oALL_DONE;
  logic          oBUSY;
`ifdef MEM_W_CTRL_OVF_CHK_EN
  logic          oERR;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  mem_w_ctrl #(.DW(DW)) dut (
    .iCLK        (iCLK),
    .iRSTn       (iRSTn),
    .iSTART_BWN  (iSTART_BWN),
    .iSTART_BNN  (iSTART_BNN),
    .iWR_VALID   (iWR_VALID),
    .iWDATA      (iWDATA),
    .oWADDR      (oWADDR),
    .oWDATA      (oWDATA),
    .oEN_WC      (oEN_WC),
    .oSTAGE_DONE (oSTAGE_DONE),
    .oALL_DONE   (oALL_DONE),
`ifdef MEM_W_CTRL_OVF_CHK_EN
    .oERR        (oERR),
`endif
    .oBUSY       (oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Check every output against its reset value.
  task automatic check_reset_outputs(input string tag);
    check({tag, " en"},   32'(oEN_WC),      32'd0);
    check({tag, " addr"}, 32'(oWADDR),      32'd0);
    check({tag, " data"}, 32'(oWDATA),      32'd0);
    check({tag, " sdone"},32'(oSTAGE_DONE), 32'd0);
    check({tag, " adone"},32'(oALL_DONE),   32'd0);
    check({tag, " busy"}, 32'(oBUSY),       32'd0);
  endtask

  // One clock with a start request; expects the FSM to leave idle.
  task automatic start_stage(input logic bwn, input logic [3:0] bnn);
    iSTART_BWN = bwn;
    iSTART_BNN = bnn;
    tick();
    iSTART_BWN = 1'b0;
    iSTART_BNN = 4'b0000;
    check("start busy", 32'(oBUSY),  32'd1);
    check("start en",   32'(oEN_WC), 32'd0);
  endtask

  // One clock with a start request that must be ignored.
  task automatic start_ignored(input string tag, input logic bwn,
                               input logic [3:0] bnn);
    iSTART_BWN = bwn;
    iSTART_BNN = bnn;
    tick();
    iSTART_BWN = 1'b0;
    iSTART_BNN = 4'b0000;
    check(tag, 32'(oBUSY), 32'd0);
  endtask

  // Feed words first..n-1 of a stage, data = i ^ salt, with `gap` idle cycles
  // between strobes. If the stage completes (last=1), the cycle after the last
  // word must show oSTAGE_DONE (and oALL_DONE when exp_all), and the cycle
  // after that must be idle. drop_in_stg holds the strobe high through the
  // stage-end cycle, which must not produce a write.
  task automatic run_words(input int first, input int n, input int gap,
                           input logic [7:0] salt, input bit last,
                           input bit exp_all, input bit drop_in_stg);
    logic [7:0] d;
    for (int i = first; i < n; i++) begin
      d = 8'(i) ^ salt;
      iWR_VALID = 1'b1;
      iWDATA    = d;
      tick();
      check("wr en",   32'(oEN_WC), 32'd1);
      check("wr addr", 32'(oWADDR), 32'(i));
      check("wr data", 32'(oWDATA), 32'(d));
      check("wr sdone", 32'(oSTAGE_DONE), 32'(last && i == n - 1));
      check("wr adone", 32'(oALL_DONE),   32'(last && exp_all && i == n - 1));
      check("wr busy",  32'(oBUSY), 32'd1);
      if (gap > 0 && i < n - 1) begin
        iWR_VALID = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick();
          check("gap en",   32'(oEN_WC), 32'd0);
          check("gap addr", 32'(oWADDR), 32'(i));
        end
      end
    end
    if (last) begin
      if (drop_in_stg) begin
        iWR_VALID = 1'b1;
        iWDATA    = 8'h77;
      end else begin
        iWR_VALID = 1'b0;
      end
      tick();
      iWR_VALID = 1'b0;
      check("post en",    32'(oEN_WC),      32'd0);
      check("post addr",  32'(oWADDR),      32'(n - 1));
      check("post data",  32'(oWDATA),      32'(8'(n - 1) ^ salt));
      check("post sdone", 32'(oSTAGE_DONE), 32'd0);
      check("post adone", 32'(oALL_DONE),   32'd0);
      check("post busy",  32'(oBUSY),       32'd0);
    end
  endtask

  initial begin
    iRSTn      = 1'b0;
    iSTART_BWN = 1'b0;
    iSTART_BNN = 4'b0000;
    iWR_VALID  = 1'b0;
    iWDATA     = '0;

    // ---- reset state ---------------------------------------------------------
    #12;
    check_reset_outputs("rst");
`ifdef MEM_W_CTRL_OVF_CHK_EN
    check("rst err", 32'(oERR), 32'd0);
`endif
    @(negedge iCLK);
    iRSTn = 1'b1;
    tick();
    check("idle busy", 32'(oBUSY), 32'd0);

    // ---- reset in the middle of phase A stage 0 at word 100 ----------------
    start_stage(1'b1, 4'b0000);
    run_words(0, 100, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    iWR_VALID = 1'b1;
    iWDATA    = 8'd100;
    iRSTn     = 1'b0;
    #1;
    check_reset_outputs("midrst");
    iWR_VALID = 1'b0;
    @(negedge iCLK);
    iRSTn = 1'b1;
    tick();
    check_reset_outputs("postrst");

    // ---- start together with a strobe: start taken, strobe dropped ---------
`ifdef MEM_W_CTRL_OVF_CHK_EN
    check("pre err", 32'(oERR), 32'd0);
`endif
    iWR_VALID = 1'b1;
    iWDATA    = 8'hEE;
    start_stage(1'b1, 4'b0000);
    iWR_VALID = 1'b0;
    check("startdrop addr", 32'(oWADDR), 32'd0);
`ifdef MEM_W_CTRL_OVF_CHK_EN
    check("startdrop err", 32'(oERR), 32'd1);
`endif

    // ---- phase A: 48 contiguous stages of 238, data == addr ----------------
    // Stage 0 restarts from word 0 because the reset discarded the partial one.
    run_words(0, 238, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int s = 1; s < 48; s++) begin
      if (s == 47) start_ignored("A47 bnn ign", 1'b0, 4'b0010);
      start_stage(1'b1, 4'b0000);
      run_words(0, 238, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // ---- in W_IDLE_B: wrong codes ignored, then phase B ---------------------
    start_ignored("B bwn ign",  1'b1, 4'b0000);
    start_ignored("B 0100 ign", 1'b0, 4'b0100);
    start_ignored("B 1000 ign", 1'b0, 4'b1000);
    for (int s = 0; s < 48; s++) begin
      start_stage(1'b0, 4'b0010);
      run_words(0, 154, 2, 8'(s * 5 + 1), 1'b1, 1'b0, 1'b0);
    end

    // ---- in W_IDLE_C: stray strobe dropped ----------------------------------
    iWR_VALID = 1'b1;
    iWDATA    = 8'h5A;
    tick();
    iWR_VALID = 1'b0;
    check("idleC en",   32'(oEN_WC), 32'd0);
    check("idleC addr", 32'(oWADDR), 32'd153);
`ifdef MEM_W_CTRL_OVF_CHK_EN
    check("idleC err",  32'(oERR),   32'd1);
`endif
    start_ignored("C 0010 ign", 1'b0, 4'b0010);

    // ---- phase C: 48 contiguous stages of 108 ------------------------------
    for (int s = 0; s < 48; s++) begin
      start_stage(1'b0, 4'b0100);
      run_words(0, 108, 0, 8'(s * 3 + 2), 1'b1, 1'b0, 1'b0);
    end

    // ---- phase D: 5 loops of 54; loop 0 holds the strobe into W_STG_D -----
    start_ignored("D 0100 ign", 1'b0, 4'b0100);
    for (int l = 0; l < 5; l++) begin
      start_stage(1'b0, 4'b1000);
      run_words(0, 54, 0, 8'(l * 40 + 3), 1'b1, (l == 4), (l == 0));
    end

    // ---- back in W_IDLE_A --------------------------------------------------
    start_ignored("A2 1000 ign", 1'b0, 4'b1000);
    start_stage(1'b1, 4'b0000);
    run_words(0, 3, 0, 8'hC3, 1'b0, 1'b0, 1'b0);
`ifdef MEM_W_CTRL_OVF_CHK_EN
    check("held err", 32'(oERR), 32'd1);
`endif
    iRSTn = 1'b0;
    #1;
    check_reset_outputs("final rst");
`ifdef MEM_W_CTRL_OVF_CHK_EN
    check("final err", 32'(oERR), 32'd0);
`endif
    iRSTn = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mem_w_ctrl.md
Name: mem_w_ctrl

Overview:
- Write-side RAM controller for the BWN/BNN accelerator; the counterpart of the RAM read sequencer.
- Accepts word strobes from the current producer: the SPI loader, then Conv1, Conv2 and Conv3 result streams.
- For each accepted strobe, generates a registered write address, write enable and write data for the shared feature RAM.
- Sequences the same phase/stage structure as the read side: 48 stages for each of three phases, then 5 FC loops.

Parameters:
- DW, 8, write data width.
- CNT_A, 238, words per stage, SPI -> RAM (addr 0..237).
- CNT_B, 154, words per stage, Conv1 -> RAM.
- CNT_C, 108, words per stage, Conv2 -> RAM.
- CNT_D, 54, words per loop, Conv3 -> RAM.
- CNT_STAGE, 48, stages per phase A/B/C.
- CNT_STAGE_FC, 5, loops in phase D.

Ports:
- iCLK  in  1  clock, rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iSTART_BWN  in  1  arm phase A stage.
- iSTART_BNN  in  4  one-hot arm: 0010 phase B, 0100 phase C, 1000 phase D.
- iWR_VALID  in  1  producer word strobe.
- iWDATA  in  DW  producer word.
- oWADDR  out  8  RAM write address.
- oWDATA  out  DW  RAM write data.
- oEN_WC  out  1  RAM write enable.
- oSTAGE_DONE  out  1  one-cycle pulse at end of each stage/loop.
- oALL_DONE  out  1  one-cycle pulse after the last FC loop.
- oBUSY  out  1  high in any write state.

Behaviour:
- Reset (iRSTn=0, async):
  - FSM to W_IDLE_A; all counters to 0.
  - oWADDR=0, oWDATA=0, oEN_WC=0, oSTAGE_DONE=0, oALL_DONE=0, oBUSY=0.
- States and transitions:
  - W_IDLE_A --iSTART_BWN--> W_A --word CNT_A-1 accepted--> W_STG_A.
  - W_STG_A --stage==CNT_STAGE-1--> W_IDLE_B, else --> W_IDLE_A.
  - W_IDLE_B --iSTART_BNN==0010--> W_B --word CNT_B-1--> W_STG_B --stage last--> W_IDLE_C, else --> W_IDLE_B.
  - W_IDLE_C --0100--> W_C --word CNT_C-1--> W_STG_C --stage last--> W_IDLE_D, else --> W_IDLE_C.
  - W_IDLE_D --1000--> W_D --word CNT_D-1--> W_STG_D --loop==CNT_STAGE_FC-1--> W_IDLE_A with oALL_DONE pulse, else --> W_IDLE_D.
  - iSTART_BNN values other than the expected code are ignored.
- Write path:
  - Only in W_A/W_B/W_C/W_D with iWR_VALID=1.
  - Next cycle: oEN_WC=1, oWADDR=word counter value before increment, oWDATA=iWDATA captured. Latency 1 clock.
  - oEN_WC is 0 in every cycle without an accepted strobe; oWADDR/oWDATA hold their last values.
- Address width rules:
  - Phase A/B counters are 8 bit.
  - Phase C counter is 7 bit, zero-extended to 8.
  - Phase D counter is 6 bit, zero-extended to 8.
- Word counter:
  - Increments only on an accepted strobe.
  - Clears to 0 on the accept of the last word (CNT_x-1).
  - Never exceeds CNT_x-1.
- Stage/loop counters:
  - Increment in W_STG_x.
  - Stage counter clears when it reaches CNT_STAGE-1 in a STG state.
  - FC counter clears at CNT_STAGE_FC-1.
- oSTAGE_DONE=1 for the single cycle the FSM is in any W_STG_x state.
- oBUSY=1 in W_A/W_B/W_C/W_D/W_STG_x.
- Boundary conditions:
  - iWR_VALID in IDLE or STG states: dropped, no write.
  - A start and iWR_VALID in the same cycle: the start is taken and the strobe is dropped. The first word is accepted the following cycle.
  - Back-to-back strobes every cycle: one write per cycle, no gaps.
  - Reset mid-stage: writes stop immediately; a partial stage is discarded.

Optional Feature:
- Macro MEM_W_CTRL_OVF_CHK_EN.
- Defined:
  - Adds output oERR (1 bit, reset 0).
  - oERR sets sticky on any iWR_VALID arriving in an IDLE or STG state.
  - oERR clears only on reset.
- Undefined:
  - Port absent; dropped strobes are silent.
- Write behaviour is identical in both cases.

Test Plan:
- Reset with iRSTn=0 mid-W_A at word 100 -> all outputs 0. After release, iSTART_BWN then 238 strobes write addr 0..237, and oSTAGE_DONE pulses once.
- Phase A, 48 stages of 238 contiguous strobes with data=addr -> oEN_WC high for 238 consecutive cycles per stage, oWDATA==oWADDR, FSM reaches W_IDLE_B after stage 47.
- Phase B with gapped strobes (valid 1 of 3 cycles) -> 154 writes, addr 0..153 monotonic, no write in gap cycles.
- iSTART_BNN=0100 applied while in W_IDLE_B -> no transition. Then 0010 -> W_B.
- Phase D, 5 loops of 54 strobes -> oWADDR max 53 with upper 2 bits 0, oALL_DONE single pulse after loop 4, FSM back in W_IDLE_A.
- With MEM_W_CTRL_OVF_CHK_EN: iWR_VALID in W_IDLE_C -> no write, oERR=1 and held until reset. Without the macro -> no write, no error port.
